// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter feeding the coherence bus request port, one transaction in flight.
// Optional WAIT_DONE watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 26,
    parameter int LINE_W  = 512,
    parameter int REQ_W   = 2,
    parameter int TIMEOUT = 1024,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          l1_req_valid,
    output logic [N_REQ-1:0]          l1_req_ready,
    input  logic [N_REQ*ADDR_W-1:0]   l1_req_addr,
    input  logic [N_REQ*REQ_W-1:0]    l1_req,
    input  logic [N_REQ*LINE_W-1:0]   l1_req_data,
    output logic                      bus_req_valid,
    input  logic                      bus_req_ready,
    output logic [ADDR_W-1:0]         bus_req_addr,
    output logic [REQ_W-1:0]          bus_req,
    output logic [LINE_W-1:0]         bus_req_data,
    input  logic                      bus_done,
    output logic [ID_W-1:0]           grant_id,
    output logic                      arb_busy,
    output logic                      arb_timeout
);

    typedef enum logic [1:0] {
        ARB,
        OFFER,
        WAIT_DONE
    } state_e;

    state_e          state_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] grant_q;
    logic [ID_W-1:0] sel_d;
    logic [ID_W-1:0] ptr_inc_d;
    logic            any_d;
    logic            offer;
    logic            accept;

    // Search from rr_ptr upward with explicit wrap so any N_REQ works.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] j;
        any_d = 1'b0;
        sel_d = rr_ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            j = ID_W'(idx);
            if (!any_d && l1_req_valid[j]) begin
                any_d = 1'b1;
                sel_d = j;
            end
        end
    end

    always_comb begin
        ptr_inc_d = '0;
        if (int'(grant_q) != N_REQ - 1) ptr_inc_d = grant_q + ID_W'(1);
    end

    assign offer  = (state_q == OFFER);
    assign accept = offer && bus_req_ready;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ARB;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                ARB: begin
                    if (any_d) begin
                        grant_q <= sel_d;
                        state_q <= OFFER;
                    end
                end
                OFFER: begin
                    if (bus_req_ready) begin
                        rr_ptr_q <= ptr_inc_d;
                        cnt_q    <= '0;
                        state_q  <= WAIT_DONE;
                    end else if (!l1_req_valid[grant_q]) begin
                        state_q <= ARB;
                    end
                end
                WAIT_DONE: begin
                    if (bus_done) begin
                        state_q <= ARB;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= ARB;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign arb_timeout = timeout_q;
`else
    logic unused_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            unique case (state_q)
                ARB: begin
                    if (any_d) begin
                        grant_q <= sel_d;
                        state_q <= OFFER;
                    end
                end
                OFFER: begin
                    if (bus_req_ready) begin
                        rr_ptr_q <= ptr_inc_d;
                        state_q  <= WAIT_DONE;
                    end else if (!l1_req_valid[grant_q]) begin
                        state_q <= ARB;
                    end
                end
                WAIT_DONE: begin
                    if (bus_done) state_q <= ARB;
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign unused_timeout = (TIMEOUT > 0);
    assign arb_timeout    = 1'b0;
`endif

    assign bus_req_valid = offer;
    assign l1_req_ready  = accept ? (N_REQ'(1) << grant_q) : '0;
    assign bus_req_addr  = offer ? l1_req_addr[grant_q*ADDR_W +: ADDR_W] : '0;
    assign bus_req       = offer ? l1_req[grant_q*REQ_W +: REQ_W] : '0;
    assign bus_req_data  = offer ? l1_req_data[grant_q*LINE_W +: LINE_W] : '0;
    assign grant_id      = grant_q;
    assign arb_busy      = (state_q != ARB);

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter with a grant scoreboard.
// Timeout step runs only when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 26;
    localparam int LW = 512;
    localparam int RW = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    l1_req_valid;
    logic [N-1:0]    l1_req_ready;
    logic [N*AW-1:0] l1_req_addr;
    logic [N*RW-1:0] l1_req;
    logic [N*LW-1:0] l1_req_data;
    logic            bus_req_valid;
    logic            bus_req_ready;
    logic [AW-1:0]   bus_req_addr;
    logic [RW-1:0]   bus_req;
    logic [LW-1:0]   bus_req_data;
    logic            bus_done;
    logic [1:0]      grant_id;
    logic            arb_busy;
    logic            arb_timeout;

    always #5 clk = ~clk;

    bus_rr_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .LINE_W(LW), .REQ_W(RW), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .l1_req_valid(l1_req_valid), .l1_req_ready(l1_req_ready),
        .l1_req_addr(l1_req_addr), .l1_req(l1_req),
        .l1_req_data(l1_req_data),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_addr(bus_req_addr), .bus_req(bus_req),
        .bus_req_data(bus_req_data), .bus_done(bus_done),
        .grant_id(grant_id), .arb_busy(arb_busy),
        .arb_timeout(arb_timeout)
    );

    logic [AW-1:0] a_addr[N];
    logic [RW-1:0] a_req[N];
    logic [LW-1:0] a_data[N];
    int            exp_q[$];
    int            hist[$];
    int            n_asserts = 0;
    int            n_fail    = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted offer must match the next queued core.
    always @(negedge clk) begin
        if (reset_n && bus_req_valid && bus_req_ready) begin
            hist.push_back(int'(grant_id));
            chk("sb_nonempty", LW'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                int e;
                e = exp_q.pop_front();
                chk("sb_grant", grant_id, e);
                chk("sb_addr", bus_req_addr, a_addr[e]);
                chk("sb_req", bus_req, a_req[e]);
                chk("sb_data", bus_req_data, a_data[e]);
                chk("sb_ready", l1_req_ready, 4'b0001 << e);
            end
        end
    end

    task automatic wait_offer();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (bus_req_valid) return;
            chk("idle_no_ready", l1_req_ready, 0);
        end
        chk("offer_seen", bus_req_valid, 1);
    endtask

    task automatic finish_txn(input int gap, input logic [N-1:0] drop);
        @(posedge clk);
        #1;
        l1_req_valid = l1_req_valid & ~drop;
        chk("wait_no_valid", bus_req_valid, 0);
        chk("wait_busy", arb_busy, 1);
        repeat (gap - 1) @(posedge clk);
        #1 bus_done = 1'b1;
        @(posedge clk);
        #1 bus_done = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ready"}, l1_req_ready, 0);
        chk({tag, "_valid"}, bus_req_valid, 0);
        chk({tag, "_addr"}, bus_req_addr, 0);
        chk({tag, "_req"}, bus_req, 0);
        chk({tag, "_data"}, bus_req_data, 0);
        chk({tag, "_busy"}, arb_busy, 0);
        chk({tag, "_tmo"}, arb_timeout, 0);
        chk({tag, "_gid"}, grant_id, 0);
    endtask

    initial begin
        logic [N-1:0] m;
        reset_n       = 1'b1;
        l1_req_valid  = '0;
        bus_req_ready = 1'b0;
        bus_done      = 1'b0;
        for (int i = 0; i < N; i++) begin
            a_addr[i] = AW'($urandom());
            a_req[i]  = RW'(i + 1);
            for (int w = 0; w < LW / 32; w++) a_data[i][w*32 +: 32] = $urandom();
            l1_req_addr[i*AW +: AW] = a_addr[i];
            l1_req[i*RW +: RW]      = a_req[i];
            l1_req_data[i*LW +: LW] = a_data[i];
        end
        #2 reset_n = 1'b0;
        #1 chk_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Contention: all cores valid, order 0,1,2,3,0.
        bus_req_ready = 1'b1;
        l1_req_valid  = 4'hF;
        exp_q = '{0, 1, 2, 3, 0};
        for (int t = 0; t < 5; t++) begin
            wait_offer();
            finish_txn(3, (t == 4) ? 4'hF : 4'h0);
        end
        m = '0;
        for (int i = 0; i < 4 && i < hist.size(); i++) m |= 4'b0001 << hist[i];
        chk("distinct4", m, 4'hF);

        // Single request from core 2, ready on the first offer cycle.
        l1_req_valid = 4'b0100;
        exp_q.push_back(2);
        @(negedge clk);
        chk("single_arb_novalid", bus_req_valid, 0);
        @(negedge clk);
        chk("single_valid", bus_req_valid, 1);
        chk("single_ready", l1_req_ready, 4'b0100);
        chk("single_gid", grant_id, 2);
        finish_txn(3, 4'b0100);
        chk("single_rr", dut.rr_ptr_q, 3);

        // Wrap-around from rr_ptr=3 with cores 1 and 3.
        l1_req_valid = 4'b1010;
        exp_q.push_back(3);
        exp_q.push_back(1);
        wait_offer();
        finish_txn(3, 4'b1000);
        wait_offer();
        finish_txn(3, 4'b0010);
        chk("wrap_rr", dut.rr_ptr_q, 2);

        // Withdrawn request while the bus holds ready low.
        bus_req_ready = 1'b0;
        l1_req_valid  = 4'b0010;
        wait_offer();
        chk("wd_gid", grant_id, 1);
        chk("wd_noready", l1_req_ready, 0);
        @(posedge clk);
        #1 l1_req_valid = 4'b0000;
        @(posedge clk);
        #1;
        chk("wd_arb", arb_busy, 0);
        chk("wd_novalid", bus_req_valid, 0);
        chk("wd_noready2", l1_req_ready, 0);
        chk("wd_rr", dut.rr_ptr_q, 2);
        bus_req_ready = 1'b1;
        l1_req_valid  = 4'b1001;
        exp_q.push_back(3);
        wait_offer();
        finish_txn(3, 4'b1001);

        // Ready and valid drop in the same cycle: acceptance wins.
        bus_req_ready = 1'b0;
        l1_req_valid  = 4'b0001;
        wait_offer();
        @(posedge clk);
        #1;
        exp_q.push_back(0);
        bus_req_ready = 1'b1;
        l1_req_valid  = 4'b0000;
        finish_txn(3, 4'b0000);
        chk("simul_rr", dut.rr_ptr_q, 1);

        // Reset during WAIT_DONE.
        l1_req_valid = 4'hF;
        exp_q.push_back(1);
        wait_offer();
        @(posedge clk);
        #1 chk("rst_busy_before", arb_busy, 1);
        #2 reset_n = 1'b0;
        #1 chk_zero_outputs("midrst");
        chk("midrst_rr", dut.rr_ptr_q, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        exp_q.push_back(0);
        wait_offer();
        finish_txn(3, 4'hF);

`ifdef BUS_ARB_TIMEOUT_EN
        l1_req_valid = 4'b0100;
        exp_q.push_back(2);
        exp_q.push_back(2);
        wait_offer();
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("tmo_k%0d", k), arb_timeout, k == 8);
        end
        wait_offer();
        finish_txn(3, 4'b0100);
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
